// File: rtl/reg_scoreboard_pkg.sv
// Shared widths and helpers for the register-write scoreboard.
// Replaces the old bus.v header constants (register address bus, register count, counter width).
package reg_scoreboard_pkg;

    localparam int unsigned SbRegNum = 32;
    localparam int unsigned SbAddrW  = 5;
    localparam int unsigned SbCntW   = 2;

    typedef logic [SbAddrW-1:0] sb_addr_t;
    typedef logic [SbCntW-1:0]  sb_cnt_t;

    function automatic int unsigned sb_cnt_max(input int unsigned width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// Saturating up/down in-flight counter for one register; flags decrements seen at zero.
module reg_scoreboard_sb_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic dec_i,
    input  logic clr_i,
    output logic zero_o,
    output logic max_o,
    output logic underflow_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign zero_o = (cnt_q == '0);
    assign max_o  = (cnt_q == '1);

    // A matched inc/dec nets to zero, so an empty counter is not an underflow then.
    assign underflow_o = dec_i & ~inc_i & ~clr_i & zero_o;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !dec_i && !max_o) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec_i && !inc_i && !zero_o) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// ID-stage scoreboard: counts in-flight register writes and loads, stalls on load-use
// hazards and on counter saturation, and latches a sticky error on counter underflow.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int unsigned REG_NUM = SbRegNum,
    parameter int unsigned ADDR_W  = SbAddrW,
    parameter int unsigned CNT_W   = SbCntW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic              id_read_en_1,
    input  logic [ADDR_W-1:0] id_read_addr_1,
    input  logic              id_read_en_2,
    input  logic [ADDR_W-1:0] id_read_addr_2,
    input  logic              id_write_en,
    input  logic [ADDR_W-1:0] id_write_addr,
    input  logic              id_is_load,
    input  logic              mem_ld_done,
    input  logic [ADDR_W-1:0] mem_ld_addr,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic              sb_clear,
    output logic              id_stall,
    output logic              sb_empty,
    output logic              sb_err
);

    // Bit 0 of every per-register vector stays tied off so that $0 never tracks or stalls.
    logic [REG_NUM-1:0] pend_busy, pend_full, pend_uf;
    logic [REG_NUM-1:0] load_busy, load_full, load_uf;
    logic               haz, full, fire;
    logic               err_q, err_d;
    logic               unused_load_full;

    assign pend_busy[0] = 1'b0;
    assign pend_full[0] = 1'b0;
    assign pend_uf[0]   = 1'b0;
    assign load_busy[0] = 1'b0;
    assign load_full[0] = 1'b0;
    assign load_uf[0]   = 1'b0;

    // Load count never exceeds the pending count, so the pending counter alone gates issue.
    assign unused_load_full = |load_full;

    for (genvar r = 1; r < REG_NUM; r++) begin : g_reg
        logic inc_pend, inc_load, dec_pend, dec_load;
        logic pend_zero, load_zero;

        assign inc_pend = fire & id_write_en & (id_write_addr == ADDR_W'(r));
        assign inc_load = inc_pend & id_is_load;
        assign dec_pend = wb_en & (wb_addr == ADDR_W'(r));
        assign dec_load = mem_ld_done & (mem_ld_addr == ADDR_W'(r));

        reg_scoreboard_sb_counter #(
            .CNT_W (CNT_W)
        ) u_pend_cnt (
            .clk         (clk),
            .rst_n       (rst_n),
            .inc_i       (inc_pend),
            .dec_i       (dec_pend),
            .clr_i       (sb_clear),
            .zero_o      (pend_zero),
            .max_o       (pend_full[r]),
            .underflow_o (pend_uf[r])
        );

        reg_scoreboard_sb_counter #(
            .CNT_W (CNT_W)
        ) u_load_cnt (
            .clk         (clk),
            .rst_n       (rst_n),
            .inc_i       (inc_load),
            .dec_i       (dec_load),
            .clr_i       (sb_clear),
            .zero_o      (load_zero),
            .max_o       (load_full[r]),
            .underflow_o (load_uf[r])
        );

        assign pend_busy[r] = ~pend_zero;
        assign load_busy[r] = ~load_zero;
    end

    always_comb begin
        haz      = (id_read_en_1 & load_busy[id_read_addr_1])
                 | (id_read_en_2 & load_busy[id_read_addr_2]);
        full     = id_write_en & pend_full[id_write_addr];
        id_stall = id_valid & ~sb_clear & (haz | full);
        fire     = id_valid & ~id_stall & ~sb_clear;
        sb_empty = ~|pend_busy;
        err_d    = err_q | (|pend_uf) | (|load_uf);
        sb_err   = err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

endmodule
